// File: rtl/reg374_bus_scheduler.sv
// Round-robin scheduler for N_SLOT 74LS374-style registers on one shared 8-bit bus.
// Drives each slot's latch clock and output enable, with dead turnaround cycles after every operation.
module reg374_bus_scheduler #(
  parameter int N_SLOT   = 4,
  parameter int RD_CYC   = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SLOT-1:0] req,
  input  logic [N_SLOT-1:0] req_wr,
  output logic [N_SLOT-1:0] grant,
  output logic              gnt_wr,
  output logic [N_SLOT-1:0] le_clk,
  output logic [N_SLOT-1:0] oe_n,
  output logic              sample,
  output logic              done,
  output logic              busy
);

  localparam int PW   = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int MAXC = (RD_CYC > TURN_CYC) ? RD_CYC : TURN_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, GRANT, LATCH, DRIVE, TURN} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   rr_nxt;
  logic [N_SLOT-1:0] win_oh;

  // Scan upward from rr_ptr, wrapping at N_SLOT-1; the first requester found wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_SLOT; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N_SLOT) j = j - N_SLOT;
      if (!found && req[PW'(j)]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
    rr_nxt = (win == PW'(N_SLOT - 1)) ? '0 : win + 1'b1;
    win_oh = N_SLOT'(1) << win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      grant  <= '0;
      gnt_wr <= 1'b0;
      le_clk <= '0;
      oe_n   <= '1;
      sample <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; strobes default off so only the active state raises them.
      le_clk <= '0;
      oe_n   <= '1;
      sample <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state  <= GRANT;
            grant  <= win_oh;
            gnt_wr <= req_wr[win];
            rr_ptr <= rr_nxt;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          if (gnt_wr) begin
            state  <= LATCH;
            le_clk <= grant;
          end else begin
            state  <= DRIVE;
            oe_n   <= ~grant;
            cnt    <= CW'(RD_CYC - 1);
            sample <= (RD_CYC == 1);
          end
        end
        LATCH: begin
          state <= TURN;
          cnt   <= CW'(TURN_CYC - 1);
          done  <= (TURN_CYC == 1);
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            oe_n   <= ~grant;
            sample <= (cnt == CW'(1));
          end else begin
            state <= TURN;
            cnt   <= CW'(TURN_CYC - 1);
            done  <= (TURN_CYC == 1);
          end
        end
        TURN: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
          end else begin
            state  <= IDLE;
            grant  <= '0;
            gnt_wr <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          grant  <= '0;
          gnt_wr <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg374_bus_scheduler.sv
// Self-checking bench: a schedule-queue model predicts every output cycle, plus hand-computed directed sequences.
module tb_reg374_bus_scheduler;

  localparam int N  = 4;
  localparam int RD = 2;
  localparam int TC = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, req_wr;
  logic [N-1:0] grant, le_clk, oe_n;
  logic         gnt_wr, sample, done, busy;

  reg374_bus_scheduler #(.N_SLOT(N), .RD_CYC(RD), .TURN_CYC(TC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
    .grant(grant), .gnt_wr(gnt_wr), .le_clk(le_clk), .oe_n(oe_n),
    .sample(sample), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         gnt_wr;
    logic [N-1:0] le_clk;
    logic [N-1:0] oe_n;
    logic         sample;
    logic         done;
    logic         busy;
  } outs_t;

  outs_t act;
  assign act = {grant, gnt_wr, le_clk, oe_n, sample, done, busy};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic outs_t idle_outs();
    outs_t o;
    o      = '0;
    o.oe_n = '1;
    return o;
  endfunction

  // Model: on arbitration, the whole operation is laid out as a queue of per-cycle output words.
  outs_t cur;
  outs_t sched[$];
  int    rr;

  always @(posedge clk or negedge rst_n) begin
    outs_t o, t;
    int w;
    if (!rst_n) begin
      sched.delete();
      cur = idle_outs();
      rr  = 0;
    end else begin
      if (!cur.busy && sched.size() == 0 && req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(rr + k) % N]) w = (rr + k) % N;
        rr = (w + 1) % N;
        o        = idle_outs();
        o.busy   = 1'b1;
        o.grant  = N'(1) << w;
        o.gnt_wr = req_wr[w];
        sched.push_back(o);
        if (o.gnt_wr) begin
          t = o; t.le_clk = o.grant; sched.push_back(t);
        end else begin
          for (int c = 0; c < RD; c++) begin
            t = o; t.oe_n = ~o.grant; t.sample = (c == RD - 1); sched.push_back(t);
          end
        end
        for (int c = 0; c < TC; c++) begin
          t = o; t.done = (c == TC - 1); sched.push_back(t);
        end
      end
      cur = (sched.size() != 0) ? sched.pop_front() : idle_outs();
    end
  end

  // Bus model: the slot whose oe_n is low places its stored byte on the bus.
  logic [7:0] slot_q [N];
  function automatic logic [7:0] bus_val();
    for (int i = 0; i < N; i++)
      if (!oe_n[i]) return slot_q[i];
    return 8'hzz;
  endfunction

  int           le_cnt, smp_cnt;
  logic [N-1:0] le_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      le_cnt  = 0;
      smp_cnt = 0;
      le_prev = '0;
    end else begin
      check("outputs", 32'(act), 32'(cur));
      check("invariants", {29'd0, ($countones(~oe_n) <= 1), $onehot0(le_clk), ((~oe_n & le_clk) == '0)}, 32'd7);
      if (busy) begin
        le_cnt  += $countones(le_clk & ~le_prev);
        smp_cnt += int'(sample);
      end
      if (cur.done) begin
        check("op_strobes", {16'(le_cnt), 16'(smp_cnt)}, cur.gnt_wr ? 32'h0001_0000 : 32'h0000_0001);
        le_cnt  = 0;
        smp_cnt = 0;
      end
      le_prev = le_clk;
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0; req = '0; req_wr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 30) begin @(negedge clk); n++; end
    if (!done) check(name, 32'd0, 32'd1);
  endtask

  logic [7:0] cap;

  initial begin
    rst_n = 1'b0; req = '0; req_wr = '0;
    for (int i = 0; i < N; i++) slot_q[i] = 8'h10 + 8'(i);
    #22;
    check("reset_state", 32'(act), 32'h0078);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write on slot 2.
    @(negedge clk);
    req = 4'b0100; req_wr = 4'b0100;
    @(negedge clk);
    check("t2_grant", grant, 4'b0100); check("t2_oe_g", oe_n, 4'hF); check("t2_le_g", le_clk, 4'h0);
    @(negedge clk);
    check("t2_latch", le_clk, 4'b0100); check("t2_oe_l", oe_n, 4'hF);
    @(negedge clk);
    check("t2_done", done, 1'b1); check("t2_le_t", le_clk, 4'h0); check("t2_oe_t", oe_n, 4'hF);
    req = '0;
    @(negedge clk);
    check("t2_idle", busy, 1'b0); check("t2_grant_off", grant, 4'h0);

    // Single read on slot 1 returning 8'hAA.
    slot_q[1] = 8'hAA;
    req = 4'b0010; req_wr = 4'b0000;
    @(negedge clk);
    check("t3_grant", grant, 4'b0010); check("t3_oe_g", oe_n, 4'hF);
    @(negedge clk);
    check("t3_oe_d1", oe_n, 4'b1101); check("t3_smp_d1", sample, 1'b0);
    @(negedge clk);
    check("t3_oe_d2", oe_n, 4'b1101); check("t3_smp_d2", sample, 1'b1);
    cap = bus_val();
    check("t3_data", cap, 8'hAA);
    @(negedge clk);
    check("t3_oe_t", oe_n, 4'hF); check("t3_done", done, 1'b1);
    req = '0;
    @(negedge clk);

    // Async reset mid-read on slot 0; rr_ptr must come back at 0.
    req = 4'b0001; req_wr = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("t1_driving", oe_n, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    check("t1_oe", oe_n, 4'hF); check("t1_le", le_clk, 4'h0);
    check("t1_grant", grant, 4'h0); check("t1_busy", busy, 1'b0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0011;
    @(negedge clk);
    check("t1_rr_reset", grant, 4'b0001);
    wait_done("t1_timeout");
    req = '0;
    @(negedge clk);

    // Round-robin with all four requesting.
    reset_pulse();
    req = 4'hF; req_wr = 4'b0101;
    for (int n = 0; n < 5; n++) begin
      int idx, b;
      b = 0;
      while (grant == '0 && b < 30) begin @(negedge clk); b++; end
      if (grant == '0) begin check("t4_timeout", 32'd0, 32'd1); break; end
      idx = -1;
      for (int i = 0; i < N; i++) if (grant[i]) idx = i;
      check("t4_order", 32'(idx), 32'(n % N));
      wait_done("t4_done_timeout");
      req[idx] = 1'b0;
      @(negedge clk);
      req[idx] = 1'b1;
    end
    req = '0;
    @(negedge clk);

    // Reset during the first DRIVE cycle of slot 3.
    reset_pulse();
    req = 4'b1000; req_wr = 4'b0000;
    begin
      int b;
      b = 0;
      while (oe_n[3] && b < 30) begin @(negedge clk); b++; end
      if (oe_n[3]) check("t5_timeout", 32'd0, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_oe3", oe_n[3], 1'b1); check("t5_oe", oe_n, 4'hF);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    @(negedge clk);
    check("t5_regrant", grant, 4'b1000);
    wait_done("t5_done_timeout");
    req = '0;
    @(negedge clk);

    // Random traffic; requesters hold until their done, sometimes toggle req_wr or drop mid-op.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i] && grant[i] && done)
          req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            req_wr[i] = 1'($urandom_range(1));
          end
        end else if (grant[i] && $urandom_range(31) == 0)
          req[i] = 1'b0;
        else if ($urandom_range(15) == 0)
          req_wr[i] = ~req_wr[i];
      end
    end
    req = '0;
    begin
      int b;
      b = 0;
      while (busy && b < 30) begin @(negedge clk); b++; end
      check("final_idle", busy, 1'b0);
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
